// File: rtl/aes_engine_scheduler_if.sv
// Requester-side bundle of the AES engine scheduler: block requests, shared responses, rekey handshake.
// master = requester side, slave = scheduler side.
interface aes_engine_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*128-1:0] req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [127:0]           rsp_data;
  logic                   key_req;
  logic [127:0]           key_in;
  logic                   key_ack;
  logic                   keyed;

  modport master (
    output req_valid, req_data, key_req, key_in,
    input  req_ready, rsp_valid, rsp_data, key_ack, keyed
  );

  modport slave (
    input  req_valid, req_data, key_req, key_in,
    output req_ready, rsp_valid, rsp_data, key_ack, keyed
  );
endinterface

// File: rtl/aes_engine_scheduler.sv
// Key load / priming / halt sequencer and round-robin block arbiter in front of a pipelined AES engine.
// Optional sticky engine-valid checker (err_o) enabled by defining AES_SCHED_ERRCHK_EN.
module aes_engine_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int LATENCY       = 11,
  parameter int KEYGEN_CYCLES = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_engine_scheduler_if.slave bus,
  output logic                  eng_set_key_o,
  output logic                  eng_start_o,
  output logic                  eng_halt_o,
  output logic [127:0]          eng_key_o,
  output logic [127:0]          eng_state_o,
  input  logic [127:0]          eng_out_i,
  input  logic                  eng_out_valid_i
`ifdef AES_SCHED_ERRCHK_EN
  ,
  output logic                  err_o
`endif
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int KW    = $clog2(KEYGEN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, PRIME, KEYWAIT, RUN, DRAIN, HALT} state_t;

  state_t           state_q;
  logic [127:0]     key_q;
  logic [KW-1:0]    kcnt_q;
  logic [CNT_W-1:0] inflight_q;
  logic [ID_W-1:0]  ptr_q;
  logic             set_key_q, halt_q, ack_q, keyed_q;
  logic             tag_v_q  [LATENCY];
  logic [ID_W-1:0]  tag_id_q [LATENCY];

  logic               rekey;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] rsp_vec;
  logic               tail_v;
  int                 idx;

  // A key_req still held during the key_ack cycle belongs to the rekey that just finished.
  assign rekey  = bus.key_req && !ack_q;
  assign tail_v = tag_v_q[LATENCY-1];

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    idx       = 0;
    if (state_q == RUN && !rekey) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!grant_any && bus.req_valid[idx]) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
    grant_vec[grant_id] = grant_any;
  end

  always_comb begin
    eng_state_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_vec[k]) eng_state_o = bus.req_data[k*128 +: 128];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      kcnt_q    <= '0;
      ptr_q     <= ID_W'(NUM_REQ - 1);
      set_key_q <= 1'b0;
      halt_q    <= 1'b0;
      ack_q     <= 1'b0;
      keyed_q   <= 1'b0;
    end else begin
      set_key_q <= 1'b0;
      halt_q    <= 1'b0;
      ack_q     <= 1'b0;
      if (grant_any) ptr_q <= grant_id;
      case (state_q)
        IDLE: if (bus.key_req) begin
          key_q     <= bus.key_in;
          set_key_q <= 1'b1;
          state_q   <= LOAD;
        end
        LOAD: state_q <= PRIME;
        PRIME: begin
          kcnt_q  <= KW'(KEYGEN_CYCLES - 1);
          state_q <= KEYWAIT;
        end
        KEYWAIT: if (kcnt_q == '0) begin
          ack_q   <= 1'b1;
          keyed_q <= 1'b1;
          state_q <= RUN;
        end else begin
          kcnt_q <= kcnt_q - KW'(1);
        end
        RUN: if (rekey) begin
          key_q   <= bus.key_in;
          keyed_q <= 1'b0;
          state_q <= DRAIN;
        end
        DRAIN: if (inflight_q == '0) begin
          halt_q  <= 1'b1;
          state_q <= HALT;
        end
        HALT: begin
          set_key_q <= 1'b1;
          state_q   <= LOAD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag shift mirrors the engine pipeline; routing never looks at eng_out_valid_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_id_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= grant_any;
      tag_id_q[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({grant_any, tail_v})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
    assign rsp_vec[gi] = tail_v && (tag_id_q[LATENCY-1] == ID_W'(gi));
  end

  assign bus.req_ready  = grant_vec;
  assign bus.rsp_valid  = rsp_vec;
  assign bus.rsp_data   = tail_v ? eng_out_i : '0;
  assign bus.key_ack    = ack_q;
  assign bus.keyed      = keyed_q;
  assign eng_set_key_o  = set_key_q;
  assign eng_halt_o     = halt_q;
  assign eng_start_o    = (state_q == PRIME) || grant_any;
  assign eng_key_o      = key_q;

`ifdef AES_SCHED_ERRCHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == RUN || state_q == DRAIN) && tail_v && !eng_out_valid_i) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  logic unused_eng_valid;
  assign unused_eng_valid = eng_out_valid_i;
`endif
endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Scoreboard bench for aes_engine_scheduler with a stand-in pipelined engine.
module tb_aes_engine_scheduler;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 11;
  localparam int KG      = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_engine_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  logic         eng_set_key, eng_start, eng_halt, eng_out_valid;
  logic [127:0] eng_key, eng_state, eng_out;
`ifdef AES_SCHED_ERRCHK_EN
  logic         err;
`endif

  aes_engine_scheduler #(.NUM_REQ(NUM_REQ), .LATENCY(LAT), .KEYGEN_CYCLES(KG)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .eng_set_key_o   (eng_set_key),
    .eng_start_o     (eng_start),
    .eng_halt_o      (eng_halt),
    .eng_key_o       (eng_key),
    .eng_state_o     (eng_state),
    .eng_out_i       (eng_out),
    .eng_out_valid_i (eng_out_valid)
`ifdef AES_SCHED_ERRCHK_EN
    ,
    .err_o           (err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Stand-in cipher: any keyed bijection will do for routing checks.
  function automatic logic [127:0] enc(input logic [127:0] s, input logic [127:0] k);
    return {s[95:0], s[127:96]} ^ k ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  logic [127:0] m_key;
  logic [127:0] pipe_d [LAT];
  logic         pipe_v [LAT];
  logic         drop_valid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      if (eng_set_key) m_key <= eng_key;
      pipe_v[0] <= eng_start;
      pipe_d[0] <= enc(eng_state, m_key);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign eng_out       = pipe_d[LAT-1];
  assign eng_out_valid = pipe_v[LAT-1] & ~drop_valid;

  typedef struct {
    int           due;
    int           id;
    logic [127:0] data;
  } exp_t;
  exp_t sbq[$];

  // Monitor: every cycle the response strobe must match exactly what the scoreboard has due.
  initial begin
    exp_t                e;
    logic [NUM_REQ-1:0]  exp_v;
    forever begin
      @(negedge clk);
      exp_v = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        exp_v[e.id] = 1'b1;
        $display("rsp  cyc %0d req %0d data %h", cyc, e.id, bus.rsp_data);
        chk("rsp_data", bus.rsp_data, e.data);
      end
      chk("rsp_valid", bus.rsp_valid, exp_v);
    end
  end

  int           ptr_m      = NUM_REQ - 1;
  int           last_grant = -1000;
  logic [127:0] model_key  = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic traffic_cycle(input logic [NUM_REQ-1:0] v);
    logic [127:0]       d [NUM_REQ];
    logic [NUM_REQ-1:0] exp_ready;
    int                 g;
    step();
    bus.req_valid = v;
    for (int i = 0; i < NUM_REQ; i++) begin
      d[i] = rand128();
      bus.req_data[i*128 +: 128] = d[i];
    end
    #1;
    // Winner is the first asserted requester visited after the previous winner.
    g = -1;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (g < 0 && v[(ptr_m + k) % NUM_REQ]) g = (ptr_m + k) % NUM_REQ;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", bus.req_ready, exp_ready);
    chk("eng_start", eng_start, (g >= 0));
    if (g >= 0) begin
      chk("eng_state", eng_state, d[g]);
      $display("gnt  cyc %0d req %0d data %h", cyc, g, d[g]);
      sbq.push_back('{cyc + LAT, g, enc(d[g], model_key)});
      ptr_m      = g;
      last_grant = cyc;
    end
  endtask

  task automatic do_key(input logic [127:0] k, input bit from_run);
    int t, z, load_exp;
    int set_t = -1, set_cnt = 0, prime_t = -1, halt_t = -1, ack_t = -1, ready_bad = 0;
    logic [127:0] prime_state = '1;
    step();
    t = cyc;
    bus.key_req   = 1'b1;
    bus.key_in    = k;
    bus.req_valid = from_run ? NUM_REQ'($urandom) | 1 : '0;
    for (int n = 0; n < 300 && ack_t < 0; n++) begin
      if (n > 0) begin
        step();
        bus.req_valid = (from_run && set_t < 0 && halt_t < 0) ? NUM_REQ'($urandom) : '0;
      end
      #1;
      if (bus.req_ready != '0) ready_bad++;
      if (eng_set_key) begin
        set_cnt++;
        if (set_t < 0) set_t = cyc;
      end
      if (eng_halt && halt_t < 0) halt_t = cyc;
      if (eng_start && set_t >= 0 && prime_t < 0) begin
        prime_t     = cyc;
        prime_state = eng_state;
      end
      if (bus.key_ack) ack_t = cyc;
    end
    z        = (t + 1 > last_grant + LAT + 1) ? t + 1 : last_grant + LAT + 1;
    load_exp = from_run ? z + 2 : t + 1;
    $display("key  cyc %0d key %h ack %0d", t, k, ack_t);
    chk("set_key_time", set_t, load_exp);
    chk("set_key_cycles", set_cnt, 1);
    chk("prime_time", prime_t, load_exp + 1);
    chk("prime_state", prime_state, '0);
    chk("halt_time", halt_t, from_run ? z + 1 : -1);
    chk("ack_time", ack_t, load_exp + 2 + KG);
    chk("ready_during_rekey", ready_bad, 0);
    chk("keyed_at_ack", bus.keyed, 1'b1);
    step();
    bus.key_req   = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("ack_one_cycle", bus.key_ack, 1'b0);
    chk("eng_key", eng_key, k);
    model_key = k;
  endtask

  task automatic do_reset();
    step();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.key_req   = 1'b0;
    // Responses due in this cycle still appear; everything later is discarded.
    while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
    step();
    step();
    rst        = 1'b0;
    ptr_m      = NUM_REQ - 1;
    last_grant = -1000;
  endtask

  task automatic reset_checks();
    for (int n = 0; n < 3; n++) begin
      step();
      bus.req_valid = '1;
      #1;
      chk("rst_req_ready", bus.req_ready, '0);
      chk("rst_eng_start", eng_start, 1'b0);
      chk("rst_eng_set_key", eng_set_key, 1'b0);
      chk("rst_eng_halt", eng_halt, 1'b0);
      chk("rst_key_ack", bus.key_ack, 1'b0);
      chk("rst_keyed", bus.keyed, 1'b0);
      chk("rst_eng_state", eng_state, '0);
      chk("rst_rsp_data", bus.rsp_data, '0);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.key_req   = 1'b0;
    bus.key_in    = '0;
    do_reset();
    chk("rst_eng_key", eng_key, '0);
    reset_checks();
    do_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    repeat (8) traffic_cycle('1);
    traffic_cycle(4'b0100);
    repeat (LAT + 1) traffic_cycle('0);
    repeat (150) traffic_cycle(NUM_REQ'($urandom));
    repeat (LAT + 1) traffic_cycle('0);
    repeat (3) traffic_cycle('1);
    do_key(rand128(), 1'b1);
    repeat (100) traffic_cycle(NUM_REQ'($urandom));
    do_key(rand128(), 1'b1);
    repeat (5) traffic_cycle('1);
    do_reset();
    reset_checks();
    do_key(rand128(), 1'b0);
    repeat (60) traffic_cycle(NUM_REQ'($urandom));
`ifdef AES_SCHED_ERRCHK_EN
    chk("err_clear", err, 1'b0);
    drop_valid = 1'b1;
    repeat (LAT + 4) traffic_cycle('1);
    drop_valid = 1'b0;
    chk("err_set", err, 1'b1);
    repeat (LAT + 2) traffic_cycle('0);
    chk("err_sticky", err, 1'b1);
    do_reset();
    #1;
    chk("err_after_rst", err, 1'b0);
`endif
    repeat (LAT + 2) traffic_cycle('0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_engine_scheduler.md
# aes_engine_scheduler

Front-end controller for the pipelined AES encrypt engine. It owns the engine's key load, key-expansion priming and halt sequencing. It shares the engine's one-block-per-cycle input among `NUM_REQ` requesters with round-robin arbitration. It routes each ciphertext back to the requester that issued it, using an internal tag pipeline matched to the engine latency.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8)
- `LATENCY`, 11: cycles from `eng_start` to the matching `eng_out`
- `KEYGEN_CYCLES`, 12: wait after priming before the first real block

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NUM_REQ  per-requester block request
- `req_data`  in  NUM_REQ*128  plaintext; requester i at bits [128i+127:128i]
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when valid&ready
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle ciphertext strobe
- `rsp_data`  out  128  ciphertext, shared by all requesters
- `key_req`  in  1  rekey request; held until `key_ack`
- `key_in`  in  128  new key, sampled when `key_req` is accepted
- `key_ack`  out  1  one-cycle pulse; new key is live
- `keyed`  out  1  high in RUN
- `eng_set_key`, `eng_start`, `eng_halt`  out  1  engine controls
- `eng_key`, `eng_state`  out  128  engine key and block inputs
- `eng_out`  in  128, `eng_out_valid`  in  1  engine outputs
- `err`  out  1  sticky; present only with `AES_SCHED_ERRCHK_EN`

## Operation
- States: IDLE, LOAD, PRIME, KEYWAIT, RUN, DRAIN, HALT.
- IDLE:
  - `key_req` latches `key_in` into the key register.
  - Next state: LOAD.
- LOAD:
  - `eng_set_key`=1 for one cycle.
  - Next state: PRIME.
- PRIME:
  - `eng_start`=1 for one cycle, with `eng_state`=0 as a dummy block.
  - The dummy block is untagged and produces no response.
  - Next state: KEYWAIT.
- KEYWAIT:
  - Count down `KEYGEN_CYCLES`.
  - At zero, go to RUN and pulse `key_ack` on RUN entry.
- RUN:
  - Round-robin grant among asserted `req_valid`.
  - Search starts at (last granted + 1) mod `NUM_REQ`.
  - The pointer advances only on a grant.
  - On grant: `eng_start`=1, `eng_state`=granted `req_data`.
  - At most one grant per cycle.
- RUN with `key_req`:
  - Latch `key_in` and go to DRAIN.
  - No grant in the cycle `key_req` is first seen.
- DRAIN:
  - No grants.
  - When the in-flight count reaches 0, go to HALT.
- HALT:
  - `eng_halt`=1 for one cycle.
  - Next state: LOAD.
- Tag pipeline:
  - `LATENCY`-deep shift of {valid, requester id}.
  - Shifted every cycle, loaded on grant.
  - At the tail, `rsp_valid[id]`=valid and `rsp_data`=`eng_out`.
  - `eng_out_valid` is never used for routing.
- In-flight counter:
  - Width clog2(`LATENCY`+1).
  - +1 on grant, -1 on tail retire; issue and retire in the same cycle leave it unchanged.
  - Can never exceed `LATENCY`.
- `req_ready` is 0 outside RUN.
- Responses have no backpressure; requesters must accept `rsp_valid` in the cycle it is asserted.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Tag pipeline cleared, counter 0, round-robin pointer set so requester 0 has top priority.
- Reset mid-operation:
  - All in-flight responses are discarded; no `rsp_valid` is generated for them.
  - The engine is reset by its own reset.
- `key_req` at cycle t in IDLE:
  - LOAD at t+1, PRIME at t+2, KEYWAIT t+3..t+2+`KEYGEN_CYCLES`.
  - `key_ack` and first possible grant at t+3+`KEYGEN_CYCLES`.
- Grant at cycle t gives `rsp_valid` at t+`LATENCY`.
- Grant outputs:
  - `req_ready` is combinational from `req_valid`, state and pointer.
  - `eng_start` and `eng_state` are combinational in the grant cycle.
- Rekey from RUN:
  - The last response retires before HALT.
  - HALT occurs the cycle after the counter reads 0.
- `key_req` asserted while already in LOAD/PRIME/KEYWAIT/DRAIN/HALT is ignored until the current `key_ack`.
- `key_req` still high at the `key_ack` cycle is not re-accepted; the requester must drop it.

## Configuration
- `AES_SCHED_ERRCHK_EN` defined:
  - Compare `eng_out_valid` with the tag-tail valid in RUN and DRAIN.
  - Any cycle where tail valid=1 and `eng_out_valid`=0 sets `err` sticky until `rst`.
- Undefined: no `err` port, no checker logic.

## Test plan
- Reset, then `key_req` with key 000102…0f → LOAD/PRIME pulses one cycle each; `key_ack` at t+15 with defaults; `keyed`=1.
- Single requester 2, plaintext 00112233…eeff under key 000102…0f → `rsp_valid`=0100 exactly 11 cycles after grant; `rsp_data`=69c4e0d86a7b0430d8cdb78070b4c55a.
- All 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
- `key_req` in RUN with 3 blocks in flight → no further grants; all 3 responses delivered; `eng_halt` pulses the cycle after the counter reaches 0; `key_ack` follows.
- Assert `rst` with 5 blocks in flight → no `rsp_valid` afterwards; `req_ready`=0 until a new key completes.
- With `AES_SCHED_ERRCHK_EN`, force `eng_out_valid`=0 at a tag tail → `err`=1 and holds until `rst`.
